// File: rtl/panda_pkg.sv
// Shared types and defaults for the iterative shifter.
package panda_pkg;

  typedef enum logic [1:0] {
    ShIdle,
    ShBusy,
    ShDone
  } shift_state_e;

  localparam int ShiftStrideDefault = 4;

endpackage

// File: rtl/panda_shift_step.sv
// One iteration of the shifter: moves the value by 1 or Stride bits in the
// requested direction, filling vacated MSBs with fill_i on right shifts.
module panda_shift_step #(
  parameter int Width  = 32,
  parameter int Stride = 4
) (
  input  logic [Width-1:0] data_i,
  input  logic             left_i,
  input  logic             fill_i,
  input  logic             stride_i,
  output logic [Width-1:0] data_o
);

  localparam logic [Width-1:0] Ones    = '1;
  localparam logic [Width-1:0] FillBig = ~(Ones >> Stride);
  localparam logic [Width-1:0] FillOne = ~(Ones >> 1);

  always_comb begin
    data_o = data_i;
    if (left_i) begin
      data_o = stride_i ? (data_i << Stride) : (data_i << 1);
    end else begin
      data_o = stride_i ? (data_i >> Stride) : (data_i >> 1);
      if (fill_i) begin
        data_o = data_o | (stride_i ? FillBig : FillOne);
      end
    end
  end

endmodule

// File: rtl/panda_shifter_iterative.sv
// Multi-cycle SLL/SRL/SRA: Stride bits per cycle while enough amount remains,
// then single bits. Valid/ready on both sides, kill aborts in-flight work.
module panda_shifter_iterative
  import panda_pkg::*;
#(
  parameter int Width       = 32,
  parameter int AmountWidth = $clog2(Width),
  parameter int Stride      = ShiftStrideDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   left_i,
  input  logic                   arithmetic_i,
  input  logic [Width-1:0]       operand_i,
  input  logic [AmountWidth-1:0] amount_i,
  input  logic                   kill_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [Width-1:0]       result_o
);

  localparam logic [AmountWidth:0]   StrideAmt = (AmountWidth + 1)'(Stride);
  // Stride == Width never takes the stride path (remaining < Width), so the wrap is harmless
  localparam logic [AmountWidth-1:0] StrideLo  = AmountWidth'(Stride % Width);

  shift_state_e           r_state;
  logic [AmountWidth-1:0] r_remaining;
  logic [Width-1:0]       r_data;
  logic [Width-1:0]       r_result;
  logic                   r_left;
  logic                   r_fill;
  logic                   r_ready;
  logic                   r_valid;

  logic                   w_big;
  logic [AmountWidth-1:0] w_step;
  logic [AmountWidth-1:0] w_rem_next;
  logic [Width-1:0]       w_step_data;

  assign w_big      = ({1'b0, r_remaining} >= StrideAmt);
  assign w_step     = w_big ? StrideLo : AmountWidth'(1);
  assign w_rem_next = r_remaining - w_step;

  panda_shift_step #(
    .Width (Width),
    .Stride(Stride)
  ) u_step (
    .data_i  (r_data),
    .left_i  (r_left),
    .fill_i  (r_fill),
    .stride_i(w_big),
    .data_o  (w_step_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ShIdle;
      r_remaining <= '0;
      r_data      <= '0;
      r_result    <= '0;
      r_left      <= 1'b0;
      r_fill      <= 1'b0;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
    end else if (kill_i) begin
      // result register deliberately untouched so a flush does not disturb result_o
      r_state <= ShIdle;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ShIdle: begin
          if (valid_i) begin
            r_data      <= operand_i;
            r_left      <= left_i;
            r_fill      <= arithmetic_i & ~left_i & operand_i[Width-1];
            r_remaining <= amount_i;
            r_ready     <= 1'b0;
            if (amount_i == '0) begin
              r_result <= operand_i;
              r_valid  <= 1'b1;
              r_state  <= ShDone;
            end else begin
              r_state <= ShBusy;
            end
          end
        end
        ShBusy: begin
          r_data      <= w_step_data;
          r_remaining <= w_rem_next;
          if (w_rem_next == '0) begin
            r_result <= w_step_data;
            r_valid  <= 1'b1;
            r_state  <= ShDone;
          end
        end
        ShDone: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ShIdle;
          end
        end
        default: begin
          r_state <= ShIdle;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = r_ready;
  assign valid_o  = r_valid;
  assign result_o = r_result;

endmodule
